// File: rtl/tile_blitter.sv
// Sprite-to-framebuffer blitter: scans a TILE x TILE palette sprite in row-major order,
// drops transparent/off-screen pixels, and emits one framebuffer write per pixel via ready/valid.
module tile_blitter #(
  parameter int          TILE   = 40,
  parameter int          FB_W   = 640,
  parameter int          FB_H   = 480,
  parameter int          ADDR_W = 19,
  parameter logic [7:0]  TRANSP = 8'd0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [9:0]                       tile_x,
  input  logic [9:0]                       tile_y,
  input  logic [0:TILE-1][0:TILE-1][7:0]   index,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_W-1:0]                fb_addr,
  output logic [7:0]                       fb_data,
  output logic                             fb_we,
  input  logic                             fb_ready
);
  localparam int CW = $clog2(TILE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [9:0]        tx, ty;
  logic [CW-1:0]     r, c;
  logic [7:0]        pix;
  logic [10:0]       xs, ys;
  logic              writable, slot_free, last, advance;
  logic [ADDR_W-1:0] addr_nx;

  assign pix       = index[r][c];
  assign xs        = {1'b0, tx} + 11'(c);
  assign ys        = {1'b0, ty} + 11'(r);
  assign writable  = (pix != TRANSP) && (xs < 11'(FB_W)) && (ys < 11'(FB_H));
  assign slot_free = !fb_we || fb_ready;
  assign last      = (r == CW'(TILE-1)) && (c == CW'(TILE-1));
  // ys < FB_H whenever this is loaded, so the product always fits ADDR_W
  assign addr_nx   = ADDR_W'(ADDR_W'(ys) * ADDR_W'(FB_W)) + ADDR_W'(xs);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        // opaque pixels wait for the slot; skipped pixels never do
        advance = !writable || slot_free;
        if (advance && last) state_nx = DRAIN;
      end
      DRAIN: if (slot_free) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx      <= '0;
      ty      <= '0;
      r       <= '0;
      c       <= '0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        tx <= tile_x;
        ty <= tile_y;
        r  <= '0;
        c  <= '0;
      end
      if (state == RUN && slot_free) begin
        fb_we <= writable;
        if (writable) begin
          fb_addr <= addr_nx;
          fb_data <= pix;
        end
      end
      if (state == DRAIN && slot_free) fb_we <= 1'b0;
      if (advance) begin
        if (c == CW'(TILE-1)) begin
          c <= '0;
          r <= last ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end
endmodule
